// File: rtl/spram_loader.sv
// Boot loader: UART byte frames -> 16-bit SPRAM words, checksum, CPU hand-over.
// Ports: rx_* byte stream in, cpu_* port in, ram_* port out, busy/done/err status.
module spram_loader #(
  parameter int unsigned TIMEOUT = 12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_load,
  input  logic [15:0] cpu_in,
  output logic [13:0] ram_addr,
  output logic        ram_load,
  output logic [15:0] ram_in,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, nxt;

  logic [7:0]    len_hi_q;
  logic [15:0]   len_q;
  logic [7:0]    hi_q;
  logic [7:0]    acc_q;
  logic [14:0]   idx_q;
  logic [TW-1:0] tcnt_q;
  logic [13:0]   wr_addr_q;
  logic [15:0]   wr_data_q;
  logic          wr_q;

  logic          timed;
  logic          tout;
  logic [15:0]   len_w;
  logic [15:0]   idx_nxt;
  logic [7:0]    csum_w;

  assign timed   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA_HI) || (state == S_DATA_LO) ||
                   (state == S_CSUM);
  assign tout    = (TIMEOUT != 0) && timed &&
                   (tcnt_q == TW'(TIMEOUT));
  assign len_w   = {len_hi_q, rx_data};
  assign idx_nxt = {1'b0, idx_q} + 16'd1;
  assign csum_w  = acc_q + rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (rx_valid && rx_data == 8'hA5) nxt = S_LEN_HI;
      S_LEN_HI:
        if (rx_valid) nxt = S_LEN_LO;
      S_LEN_LO:
        if (rx_valid) begin
          if (len_w > 16'd16384)  nxt = S_ERR;
          else if (len_w == 16'd0) nxt = S_CSUM;
          else                     nxt = S_DATA_HI;
        end
      S_DATA_HI:
        if (rx_valid) nxt = S_DATA_LO;
      S_DATA_LO:
        if (rx_valid) begin
          if (idx_nxt == len_q) nxt = S_CSUM;
          else                  nxt = S_DATA_HI;
        end
      S_CSUM:
        if (rx_valid) nxt = (csum_w == 8'd0) ? S_DONE : S_ERR;
      default: nxt = state;
    endcase
    // A byte arriving on the expiry cycle still counts as activity.
    if (tout && !rx_valid) nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q  <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_q      <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_LEN_HI: len_hi_q <= rx_data;
          S_LEN_LO: begin
            len_q <= len_w;
            idx_q <= '0;
            acc_q <= '0;
          end
          S_DATA_HI: begin
            hi_q  <= rx_data;
            acc_q <= acc_q + rx_data;
          end
          S_DATA_LO: begin
            wr_q      <= 1'b1;
            wr_addr_q <= idx_q[13:0];
            wr_data_q <= {hi_q, rx_data};
            acc_q     <= acc_q + rx_data;
            idx_q     <= idx_q + 15'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt_q <= '0;
    else if (!timed || rx_valid)
      tcnt_q <= '0;
    else if (TIMEOUT != 0 && !tout)
      tcnt_q <= tcnt_q + 1'b1;
  end

  always_comb begin
    busy     = (state != S_DONE);
    done     = (state == S_DONE);
    err      = (state == S_ERR);
    ram_addr = wr_addr_q;
    ram_in   = wr_data_q;
    ram_load = wr_q && (state != S_ERR);
    if (state == S_DONE) begin
      ram_addr = cpu_addr;
      ram_in   = cpu_in;
      ram_load = cpu_load;
    end
  end

endmodule

// File: tb/tb_spram_loader.sv
// Directed bench for spram_loader: frames, limits, timeout, hand-over, reset.
// Write log captured at negedge; checks are immediate assertions.
module tb_spram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic        cpu_load = 1'b0;
  logic [15:0] cpu_in = '0;
  logic [13:0] ram_addr;
  logic        ram_load;
  logic [15:0] ram_in;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [29:0] wlog[$];
  int run = 0;
  int maxrun = 0;

  spram_loader #(.TIMEOUT(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cpu_addr(cpu_addr),
    .cpu_load(cpu_load),
    .cpu_in(cpu_in),
    .ram_addr(ram_addr),
    .ram_load(ram_load),
    .ram_in(ram_in),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && busy && ram_load) begin
      wlog.push_back({ram_addr, ram_in});
      run = run + 1;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] wget(input int i);
    if (wlog.size() > i) return wlog[i];
    return '1;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    cpu_load = 1'b0;
    idle(2);
    rst_n = 1'b1;
    wlog.delete();
    maxrun = 0;
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load", 32'(ram_load), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_in", 32'(ram_in), 32'd0);
    do_reset();

    // Nominal frame with gaps
    send(8'hA5); idle(1);
    send(8'h00); idle(1);
    send(8'h02); idle(1);
    send(8'h12); idle(1);
    send(8'h34); idle(1);
    send(8'hAB); idle(1);
    send(8'hCD); idle(1);
    send(8'h42);
    chk("nom_done_next", 32'(done), 32'd1);
    chk("nom_busy_next", 32'(busy), 32'd0);
    chk("nom_err", 32'(err), 32'd0);
    chk("nom_nwr", 32'(wlog.size()), 32'd2);
    chk("nom_w0", 32'(wget(0)), 32'({14'd0, 16'h1234}));
    chk("nom_w1", 32'(wget(1)), 32'({14'd1, 16'hABCD}));
    chk("nom_pulse", 32'(maxrun), 32'd1);

    // CPU passthrough in DONE
    cpu_addr = 14'h0005;
    cpu_in   = 16'hBEEF;
    cpu_load = 1'b1;
    #1;
    chk("pt_addr", 32'(ram_addr), 32'h5);
    chk("pt_in", 32'(ram_in), 32'hBEEF);
    chk("pt_load", 32'(ram_load), 32'd1);
    cpu_load = 1'b0;
    #1;
    chk("pt_load0", 32'(ram_load), 32'd0);
    send(8'hA5); idle(2);
    chk("done_absorb", 32'(done), 32'd1);

    // Garbage then frame, all back-to-back
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB);
    send(8'hCD); send(8'h42);
    idle(1);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_nwr", 32'(wlog.size()), 32'd2);
    chk("b2b_w0", 32'(wget(0)), 32'({14'd0, 16'h1234}));
    chk("b2b_w1", 32'(wget(1)), 32'({14'd1, 16'hABCD}));
    chk("b2b_pulse", 32'(maxrun), 32'd1);

    // Bad checksum
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB);
    send(8'hCD); send(8'h43);
    idle(1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_busy", 32'(busy), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_nwr", 32'(wlog.size()), 32'd2);
    chk("bad_w1", 32'(wget(1)), 32'({14'd1, 16'hABCD}));
    cpu_load = 1'b1;
    #1;
    chk("bad_cpu_load", 32'(ram_load), 32'd0);
    cpu_load = 1'b0;

    // Length too large
    do_reset();
    send(8'hA5); send(8'h40); send(8'h01);
    chk("len_big_err", 32'(err), 32'd1);
    idle(2);
    chk("len_big_nwr", 32'(wlog.size()), 32'd0);

    // Zero length
    do_reset();
    send(8'hA5); send(8'h00); send(8'h00);
    chk("len0_wait", 32'(done), 32'd0);
    send(8'h00);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_nwr", 32'(wlog.size()), 32'd0);

    // Timeout: expires on the 101st idle edge
    do_reset();
    send(8'hA5); send(8'h00);
    idle(100);
    chk("to_early", 32'(err), 32'd0);
    idle(1);
    chk("to_err", 32'(err), 32'd1);

    // Reset during DATA_LO write
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("mid_load", 32'(ram_load), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_load", 32'(ram_load), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_in", 32'(ram_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h56); send(8'h78); send(8'h32);
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_w0", 32'(wget(0)), 32'({14'd0, 16'h5678}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_loader.md
# spram_loader

Boot-time loader sitting directly upstream of the 16K×16 SPRAM data/instruction memory. SPRAM has no bitstream initialisation, so this block takes a byte stream from the UART receiver, assembles 16-bit big-endian words and writes them sequentially from address 0. It then verifies a checksum and hands the RAM port over to the CPU. The CPU is held in reset (`busy`) until a load completes successfully.

## Interface
Parameters:
- `TIMEOUT`, default 12_000_000: max idle cycles between bytes once a frame has started; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx_data`  in  8  byte from UART receiver
- `rx_valid`  in  1  single-cycle strobe, `rx_data` valid
- `cpu_addr`  in  14  CPU memory address
- `cpu_load`  in  1  CPU write enable
- `cpu_in`  in  16  CPU write data
- `ram_addr`  out  14  to RAM `addr`
- `ram_load`  out  1  to RAM `load`
- `ram_in`  out  16  to RAM `in`
- `busy`  out  1  high in every state except DONE; drives CPU reset
- `done`  out  1  load completed, checksum good (sticky)
- `err`  out  1  load failed (sticky)

## Operation
- **Frame format:** `0xA5`, LEN_HI, LEN_LO, then LEN words (hi byte, lo byte), then CSUM.
- **Checksum rule:** (sum of the 2·LEN data bytes + CSUM) mod 256 == 0. The sync and length bytes are excluded.
- **States:** IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR. A byte is consumed only on `rx_valid`.
- **IDLE:** `0xA5` moves to LEN_HI. Any other byte is discarded.
- **LEN_LO:**
  - LEN > 16384 goes to ERR.
  - LEN == 0 goes straight to CSUM.
  - Otherwise go to DATA_HI. Set word index to 0 and checksum accumulator to 0.
- **DATA_HI:** latch the hi byte, add it to the accumulator, go to DATA_LO.
- **DATA_LO:**
  - Register a write: `ram_addr` = index, `ram_in` = {hi, lo}, `ram_load` = 1 for exactly one cycle.
  - Add the lo byte to the accumulator and increment the index.
  - When index reaches LEN, go to CSUM; else go to DATA_HI.
- **CSUM:** if the 8-bit check passes, go to DONE; otherwise go to ERR.
- **DONE:** `ram_addr`/`ram_load`/`ram_in` are driven combinationally from `cpu_addr`/`cpu_load`/`cpu_in`. `busy` = 0, `done` = 1.
- **ERR:** `ram_load` forced 0, `busy` = 1, `err` = 1.
- **States IDLE–CSUM:** the RAM port is owned by the loader and `cpu_*` is ignored. Outside write cycles, `ram_load` = 0.
- **Absorbing states:** DONE and ERR hold until `rst_n`. `rx_valid` is ignored there.
- **Timeout:**
  - Active in LEN_HI through CSUM. The counter clears on every `rx_valid` and on entry to LEN_HI.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT, go to ERR.
  - The counter is sized to hold TIMEOUT without overflow.
- **Widths:** index is 15 bits (holds 16384); LEN is 16 bits; accumulator is 8 bits with wrap.

## Timing
- **Reset values:** state IDLE, `ram_addr` = 0, `ram_in` = 0, `ram_load` = 0, `busy` = 1, `done` = 0, `err` = 0, all counters 0. These take effect immediately when `rst_n` falls.
- **Write latency:** LO byte `rx_valid` sampled at edge k; `ram_load`/`ram_addr`/`ram_in` are high/valid from edge k to edge k+1. RAM captures the word at edge k+1.
- **Back-to-back bytes:** `rx_valid` on consecutive cycles must be accepted with no byte dropped.
- **Last word:** a write for the last word followed immediately by a CSUM byte must still complete.
- **Hand-over:** the state register updates at the edge where the CSUM byte is sampled. `done`/`busy` change in the following cycle. The CPU passthrough is active from that same cycle.
- **Reset mid-frame:**
  - An in-flight `ram_load` is dropped asynchronously.
  - RAM contents already written are retained.
  - The block restarts in IDLE.

## Test plan
- **Nominal load:** reset, then send A5 00 02 12 34 AB CD 42. Expect:
  - writes addr 0 = 0x1234 and addr 1 = 0xABCD, each `ram_load` pulse exactly 1 cycle;
  - then `done` = 1, `busy` = 0, `err` = 0.
- **Garbage and back-to-back:** send 00 FF 5A before the nominal frame, with bytes on consecutive cycles. Expect identical writes and `done`.
- **Bad checksum:** nominal frame with CSUM 43. Expect:
  - both writes still occur;
  - `err` = 1, `busy` = 1;
  - `cpu_load` = 1 produces `ram_load` = 0.
- **Length limits:**
  - A5 40 01: expect `err` right after LEN_LO and zero writes.
  - A5 00 00 00: expect `done` with zero writes.
- **Timeout:** TIMEOUT = 100, send A5 00 then stall 101 cycles. Expect `err` = 1.
- **Passthrough and reset:**
  - After `done`, drive `cpu_addr` = 0x0005, `cpu_in` = 0xBEEF, `cpu_load` = 1. Expect the `ram_*` outputs to equal these in the same cycle.
  - Assert `rst_n` low during DATA_LO of a new frame. Expect `ram_load` = 0 immediately, `busy` = 1, `done` = 0, and the state back in IDLE.
